writeback_merge: RTL and testbench

Writeback-side collector for the multi-cycle floating point pipeline and the single-cycle integer pipeline. Accepts results from the last multi-cycle stage (mx5) and the single-cycle stage (sx), serialises them onto the single register file write port, and packs per-lane compare bits into a scalar mask. The multi-cycle pipeline cannot stall, so mx5 always wins; colliding sx results wait in a small skid FIFO. Back-pressure is reported to thread select.

---
 rtl/writeback_merge_pkg.sv | 61 ++++++
 rtl/writeback_merge_fifo.sv | 58 +++++
 rtl/writeback_merge.sv | 122 ++++++++++++
 tb/tb_writeback_merge.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_merge_pkg.sv
// Shared pipeline types plus the writeback entry format and the compare-packing helpers
// used by writeback_merge (optional WB_PERF_COUNTER_EN adds a conflict counter to the top).
package writeback_merge_pkg;

    localparam int VECTOR_LANES = 16;

    typedef logic [1:0]  thread_idx_t;
    typedef logic [3:0]  subcycle_t;
    typedef logic [4:0]  register_idx_t;
    typedef logic [31:0] scalar_t;
    typedef scalar_t [VECTOR_LANES-1:0] vector_t;

    typedef struct packed {
        logic          has_dest;
        register_idx_t dest_reg;
        logic          dest_is_vector;
        logic          is_compare;
        subcycle_t     last_subcycle;
    } decoded_instruction_t;

    typedef struct packed {
        thread_idx_t              thread_idx;
        register_idx_t            dest_reg;
        logic                     is_vector;
        logic [VECTOR_LANES-1:0]  mask;
        vector_t                  value;
        logic                     last;
    } wb_entry_t;

    // Gathers bit 0 of every lane into lane 0; all other lanes read as zero.
    function automatic vector_t pack_compare(input vector_t result);
        vector_t packed_value;
        packed_value = '0;
        for (int i = 0; i < VECTOR_LANES; i++)
            packed_value[0][i] = result[i][0];
        return packed_value;
    endfunction

    function automatic wb_entry_t make_entry(
        input decoded_instruction_t    instr,
        input logic [VECTOR_LANES-1:0] mask,
        input thread_idx_t             thread_idx,
        input subcycle_t               subcycle,
        input vector_t                 result
    );
        wb_entry_t entry;
        entry.thread_idx = thread_idx;
        entry.dest_reg   = instr.dest_reg;
        entry.mask       = mask;
        entry.last       = (subcycle == instr.last_subcycle);
        if (instr.is_compare) begin
            entry.is_vector = 1'b0;
            entry.value     = pack_compare(result);
        end else begin
            entry.is_vector = instr.dest_is_vector;
            entry.value     = result;
        end
        return entry;
    endfunction

endpackage

// File: rtl/writeback_merge_fifo.sv
// Small synchronous FIFO with registered occupancy; same-cycle push and pop allowed,
// a push into a full FIFO without a pop is dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(SIZE):0]  count,
    output logic [$clog2(SIZE):0]  count_next,
    output logic                   empty
);
    localparam int AW = $clog2(SIZE);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(SIZE);

    logic [WIDTH-1:0] mem [SIZE];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && ((count != FULL_COUNT) || do_pop);
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (do_pop && !do_push)
            count_next = count - 1'b1;
    end

    // NOTE: storage carries no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

endmodule

// File: rtl/writeback_merge.sv
// Serialises mx5 and sx results onto the single register-file write port; mx5 always wins
// and displaced sx results wait in a skid FIFO. WB_PERF_COUNTER_EN adds a conflict counter.
module writeback_merge
    import writeback_merge_pkg::*;
#(
    parameter int SKID_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mx5_instruction_valid,
    input  decoded_instruction_t     mx5_instruction,
    input  logic [VECTOR_LANES-1:0]  mx5_mask_value,
    input  thread_idx_t              mx5_thread_idx,
    input  subcycle_t                mx5_subcycle,
    input  vector_t                  mx5_result,
    input  logic                     sx_instruction_valid,
    input  decoded_instruction_t     sx_instruction,
    input  logic [VECTOR_LANES-1:0]  sx_mask_value,
    input  thread_idx_t              sx_thread_idx,
    input  subcycle_t                sx_subcycle,
    input  vector_t                  sx_result,
    output logic                     wb_writeback_en,
    output thread_idx_t              wb_writeback_thread_idx,
    output register_idx_t            wb_writeback_reg,
    output logic                     wb_writeback_is_vector,
    output logic [VECTOR_LANES-1:0]  wb_writeback_mask,
    output vector_t                  wb_writeback_value,
    output logic                     wb_writeback_last,
    output logic                     wb_sx_stall
`ifdef WB_PERF_COUNTER_EN
    ,
    output logic [31:0]              wb_perf_conflict_count
`endif
);
    localparam int CW = $clog2(SKID_DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LEVEL = CW'(SKID_DEPTH - 1);

    wb_entry_t       mx5_entry;
    wb_entry_t       sx_entry;
    wb_entry_t       head_entry;
    wb_entry_t       write_entry;
    wb_entry_t       wb_q;
    logic            mx5_relevant;
    logic            sx_relevant;
    logic            write_en;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   fifo_count_next;

    assign mx5_relevant = mx5_instruction_valid && mx5_instruction.has_dest;
    assign sx_relevant  = sx_instruction_valid && sx_instruction.has_dest;
    assign mx5_entry = make_entry(mx5_instruction, mx5_mask_value, mx5_thread_idx,
                                  mx5_subcycle, mx5_result);
    assign sx_entry  = make_entry(sx_instruction, sx_mask_value, sx_thread_idx,
                                  sx_subcycle, sx_result);

    // sx is buffered whenever it cannot go straight out, which keeps sx results in order.
    assign fifo_push = sx_relevant && (mx5_relevant || !fifo_empty);
    assign fifo_pop  = !mx5_relevant && !fifo_empty;

    always_comb begin
        write_en    = 1'b0;
        write_entry = '0;
        if (mx5_relevant) begin
            write_en    = 1'b1;
            write_entry = mx5_entry;
        end else if (!fifo_empty) begin
            write_en    = 1'b1;
            write_entry = head_entry;
        end else if (sx_relevant) begin
            write_en    = 1'b1;
            write_entry = sx_entry;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .SIZE  (SKID_DEPTH)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_data  (sx_entry),
        .pop        (fifo_pop),
        .pop_data   (head_entry),
        .count      (fifo_count),
        .count_next (fifo_count_next),
        .empty      (fifo_empty)
    );

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_writeback_en <= 1'b0;
            wb_q            <= '0;
            wb_sx_stall     <= 1'b0;
        end else begin
            wb_writeback_en <= write_en;
            wb_q            <= write_en ? write_entry : '0;
            wb_sx_stall     <= (fifo_count_next >= STALL_LEVEL);
        end
    end

    assign wb_writeback_thread_idx = wb_q.thread_idx;
    assign wb_writeback_reg        = wb_q.dest_reg;
    assign wb_writeback_is_vector  = wb_q.is_vector;
    assign wb_writeback_mask       = wb_q.mask;
    assign wb_writeback_value      = wb_q.value;
    assign wb_writeback_last       = wb_q.last;

`ifdef WB_PERF_COUNTER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wb_perf_conflict_count <= '0;
        else if (fifo_push && (wb_perf_conflict_count != 32'hffff_ffff))
            wb_perf_conflict_count <= wb_perf_conflict_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_writeback_merge.sv
// Directed bench for writeback_merge: arbitration, skid ordering, stall, compare packing,
// subcycle last flag and reset; the conflict counter is checked when WB_PERF_COUNTER_EN is set.
module tb_writeback_merge;
    import writeback_merge_pkg::*;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    mx5_instruction_valid;
    decoded_instruction_t    mx5_instruction;
    logic [VECTOR_LANES-1:0] mx5_mask_value;
    thread_idx_t             mx5_thread_idx;
    subcycle_t               mx5_subcycle;
    vector_t                 mx5_result;
    logic                    sx_instruction_valid;
    decoded_instruction_t    sx_instruction;
    logic [VECTOR_LANES-1:0] sx_mask_value;
    thread_idx_t             sx_thread_idx;
    subcycle_t               sx_subcycle;
    vector_t                 sx_result;
    logic                    wb_writeback_en;
    thread_idx_t             wb_writeback_thread_idx;
    register_idx_t           wb_writeback_reg;
    logic                    wb_writeback_is_vector;
    logic [VECTOR_LANES-1:0] wb_writeback_mask;
    vector_t                 wb_writeback_value;
    logic                    wb_writeback_last;
    logic                    wb_sx_stall;
`ifdef WB_PERF_COUNTER_EN
    logic [31:0]             wb_perf_conflict_count;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    writeback_merge #(.SKID_DEPTH(2)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .mx5_instruction_valid   (mx5_instruction_valid),
        .mx5_instruction         (mx5_instruction),
        .mx5_mask_value          (mx5_mask_value),
        .mx5_thread_idx          (mx5_thread_idx),
        .mx5_subcycle            (mx5_subcycle),
        .mx5_result              (mx5_result),
        .sx_instruction_valid    (sx_instruction_valid),
        .sx_instruction          (sx_instruction),
        .sx_mask_value           (sx_mask_value),
        .sx_thread_idx           (sx_thread_idx),
        .sx_subcycle             (sx_subcycle),
        .sx_result               (sx_result),
        .wb_writeback_en         (wb_writeback_en),
        .wb_writeback_thread_idx (wb_writeback_thread_idx),
        .wb_writeback_reg        (wb_writeback_reg),
        .wb_writeback_is_vector  (wb_writeback_is_vector),
        .wb_writeback_mask       (wb_writeback_mask),
        .wb_writeback_value      (wb_writeback_value),
        .wb_writeback_last       (wb_writeback_last),
        .wb_sx_stall             (wb_sx_stall)
`ifdef WB_PERF_COUNTER_EN
        ,
        .wb_perf_conflict_count  (wb_perf_conflict_count)
`endif
    );

    task automatic check(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic decoded_instruction_t mk_instr(input register_idx_t dest, input logic is_vec,
                                                     input logic is_cmp, input subcycle_t last_sub);
        decoded_instruction_t d;
        d.has_dest       = 1'b1;
        d.dest_reg       = dest;
        d.dest_is_vector = is_vec;
        d.is_compare     = is_cmp;
        d.last_subcycle  = last_sub;
        return d;
    endfunction

    function automatic vector_t scalar_vec(input logic [31:0] v);
        vector_t r;
        r    = '0;
        r[0] = v;
        return r;
    endfunction

    task automatic idle();
        mx5_instruction_valid = 1'b0;
        mx5_instruction       = '0;
        mx5_mask_value        = '0;
        mx5_thread_idx        = '0;
        mx5_subcycle          = '0;
        mx5_result            = '0;
        sx_instruction_valid  = 1'b0;
        sx_instruction        = '0;
        sx_mask_value         = '0;
        sx_thread_idx         = '0;
        sx_subcycle           = '0;
        sx_result             = '0;
    endtask

    task automatic drive_mx(input decoded_instruction_t instr, input logic [15:0] mask,
                            input thread_idx_t thr, input subcycle_t sub, input vector_t res);
        mx5_instruction_valid = 1'b1;
        mx5_instruction       = instr;
        mx5_mask_value        = mask;
        mx5_thread_idx        = thr;
        mx5_subcycle          = sub;
        mx5_result            = res;
    endtask

    task automatic drive_sx(input decoded_instruction_t instr, input logic [15:0] mask,
                            input thread_idx_t thr, input vector_t res);
        sx_instruction_valid = 1'b1;
        sx_instruction       = instr;
        sx_mask_value        = mask;
        sx_thread_idx        = thr;
        sx_subcycle          = '0;
        sx_result            = res;
    endtask

    initial begin
        vector_t exp_v;
        vector_t cmp_in;
        register_idx_t exp_reg;

        idle();
        #12;
        // Reset state
        check("reset_en", wb_writeback_en, 0);
        check("reset_stall", wb_sx_stall, 0);
        check("reset_value", wb_writeback_value, 0);
        reset = 1'b0;
        tick();
        check("idle_en", wb_writeback_en, 0);

        // Lone mx5 scalar
        drive_mx(mk_instr(5'd5, 1'b0, 1'b0, 4'd0), 16'h0001, 2'd2, 4'd0, scalar_vec(32'h3f80_0000));
        tick();
        idle();
        check("mx_en", wb_writeback_en, 1);
        check("mx_reg", wb_writeback_reg, 5);
        check("mx_thread", wb_writeback_thread_idx, 2);
        check("mx_value", wb_writeback_value, scalar_vec(32'h3f80_0000));
        check("mx_mask", wb_writeback_mask, 16'h0001);
        check("mx_last", wb_writeback_last, 1);
        check("mx_is_vector", wb_writeback_is_vector, 0);
        tick();
        check("mx_after_en", wb_writeback_en, 0);

        // mx5 and sx collide in one cycle
        drive_mx(mk_instr(5'd1, 1'b0, 1'b0, 4'd0), 16'h0001, 2'd0, 4'd0, scalar_vec(32'd11));
        drive_sx(mk_instr(5'd7, 1'b0, 1'b0, 4'd0), 16'h0001, 2'd1, scalar_vec(32'd42));
        tick();
        idle();
        check("col_c1_reg", wb_writeback_reg, 1);
        check("col_c1_value", wb_writeback_value, scalar_vec(32'd11));
        check("col_c1_stall", wb_sx_stall, 1);
        tick();
        check("col_c2_en", wb_writeback_en, 1);
        check("col_c2_reg", wb_writeback_reg, 7);
        check("col_c2_thread", wb_writeback_thread_idx, 1);
        check("col_c2_value", wb_writeback_value, scalar_vec(32'd42));
        check("col_c2_stall", wb_sx_stall, 0);
`ifdef WB_PERF_COUNTER_EN
        check("col_counter", wb_perf_conflict_count, 1);
`endif
        tick();
        check("col_c3_en", wb_writeback_en, 0);

        // mx5 busy four cycles, sx in cycles 0 and 1: writes mx5 r10..r13, then r20, r21
        for (int c = 0; c < 8; c++) begin
            idle();
            if (c < 4) drive_mx(mk_instr(register_idx_t'(10 + c), 1'b0, 1'b0, 4'd0), 16'h0001,
                                2'd3, 4'd0, scalar_vec(32'(100 + c)));
            if (c < 2) drive_sx(mk_instr(register_idx_t'(20 + c), 1'b0, 1'b0, 4'd0), 16'h0001,
                                2'd0, scalar_vec(32'(200 + c)));
            tick();
            if (c < 4) begin
                exp_reg = register_idx_t'(10 + c);
                check("burst_en", wb_writeback_en, 1);
                check("burst_reg", wb_writeback_reg, exp_reg);
            end else if (c < 6) begin
                exp_reg = register_idx_t'(20 + c - 4);
                check("burst_sx_en", wb_writeback_en, 1);
                check("burst_sx_reg", wb_writeback_reg, exp_reg);
                check("burst_sx_value", wb_writeback_value, scalar_vec(32'(200 + c - 4)));
            end else begin
                check("burst_drained_en", wb_writeback_en, 0);
            end
            check("burst_stall", wb_sx_stall, (c < 5) ? 1'b1 : 1'b0);
        end
`ifdef WB_PERF_COUNTER_EN
        check("burst_counter", wb_perf_conflict_count, 3);
`endif
        idle();

        // Discarded candidates: mx5 without destination lets sx go straight out
        mx5_instruction_valid = 1'b1;
        mx5_instruction       = mk_instr(5'd3, 1'b0, 1'b0, 4'd0);
        mx5_instruction.has_dest = 1'b0;
        drive_sx(mk_instr(5'd9, 1'b0, 1'b0, 4'd0), 16'h0001, 2'd1, scalar_vec(32'd9));
        tick();
        idle();
        check("nodest_reg", wb_writeback_reg, 9);
        check("nodest_stall", wb_sx_stall, 0);
        sx_instruction_valid = 1'b1;
        sx_instruction       = mk_instr(5'd4, 1'b0, 1'b0, 4'd0);
        sx_instruction.has_dest = 1'b0;
        tick();
        idle();
        check("nodest_sx_en", wb_writeback_en, 0);

        // Compare packing: lanes 0, 3, 15 have bit 0 set
        cmp_in     = '0;
        cmp_in[0]  = 32'h0000_0001;
        cmp_in[1]  = 32'h0000_0002;
        cmp_in[3]  = 32'hffff_ff01;
        cmp_in[7]  = 32'h8000_0000;
        cmp_in[15] = 32'h1234_5671;
        drive_mx(mk_instr(5'd6, 1'b1, 1'b1, 4'd0), 16'hffff, 2'd1, 4'd0, cmp_in);
        tick();
        idle();
        check("cmp_value", wb_writeback_value, scalar_vec(32'h0000_8009));
        check("cmp_is_vector", wb_writeback_is_vector, 0);
        check("cmp_mask", wb_writeback_mask, 16'hffff);

        // Vector subcycles 0..3, last only on the fourth write
        for (int s = 0; s < 4; s++) begin
            exp_v = '0;
            exp_v[s] = 32'(s + 1);
            drive_mx(mk_instr(5'd8, 1'b1, 1'b0, 4'd3), 16'h00f0, 2'd0, subcycle_t'(s), exp_v);
            tick();
            check("vec_is_vector", wb_writeback_is_vector, 1);
            check("vec_value", wb_writeback_value, exp_v);
            check("vec_last", wb_writeback_last, (s == 3) ? 1'b1 : 1'b0);
        end
        idle();

        // Reset with two sx entries buffered
        drive_mx(mk_instr(5'd1, 1'b0, 1'b0, 4'd0), 16'h0001, 2'd0, 4'd0, scalar_vec(32'd1));
        drive_sx(mk_instr(5'd20, 1'b0, 1'b0, 4'd0), 16'h0001, 2'd0, scalar_vec(32'd20));
        tick();
        drive_mx(mk_instr(5'd2, 1'b0, 1'b0, 4'd0), 16'h0001, 2'd0, 4'd0, scalar_vec(32'd2));
        drive_sx(mk_instr(5'd21, 1'b0, 1'b0, 4'd0), 16'h0001, 2'd0, scalar_vec(32'd21));
        tick();
        idle();
        check("prerst_stall", wb_sx_stall, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_en", wb_writeback_en, 0);
        check("rst_stall", wb_sx_stall, 0);
        check("rst_reg", wb_writeback_reg, 0);
        check("rst_value", wb_writeback_value, 0);
        tick();
        reset = 1'b0;
`ifdef WB_PERF_COUNTER_EN
        check("rst_counter", wb_perf_conflict_count, 0);
`endif
        for (int k = 0; k < 4; k++) begin
            tick();
            check("postrst_en", wb_writeback_en, 0);
            check("postrst_stall", wb_sx_stall, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
